vgahdmi_ram_arbiter: RTL

Two-requester arbiter that shares one single-port synchronous video RAM between the VGA/HDMI display fetch and the CPU bus. The display gets absolute priority with a fixed 2-cycle read latency, so the pixel shifter never stalls. CPU accesses are granted in the RAM-port cycles the display leaves free. The block sits between the framebuffer RAM and the display timing block, in the `clk_pixel` domain.

---
 rtl/vgahdmi_ram_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vgahdmi_ram_arbiter.sv
// Display-priority arbiter sharing one synchronous video RAM port with the CPU.
// Define VGAHDMI_ARB_STATS_EN to add the saturating conflict_cnt output.
module vgahdmi_ram_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_pixel,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_data,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_timeout,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
`ifdef VGAHDMI_ARB_STATS_EN
    ,
    output logic [15:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_CAPT,
        C_ACK
    } cpu_state_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    cpu_state_e        state_q, state_d;
    logic [7:0]        wait_q, wait_d, wait_inc;
    logic              timeout_q, timeout_d;
    logic              ack_q;
    logic              we_q;
    logic              disp_pend_q;
    logic [DATA_W-1:0] disp_data_q;
    logic [DATA_W-1:0] cpu_rdata_q;

    logic cpu_open, pend, grant, block;

    assign cpu_open = (state_q == C_IDLE) || (state_q == C_WAIT);
    assign pend     = cpu_req && cpu_open;
    assign grant    = pend && !disp_req;
    assign block    = pend && disp_req;

    // Display owns the port whenever it asks; idle cycles park on disp_addr.
    assign ram_addr  = grant ? cpu_addr : disp_addr;
    assign ram_we    = grant && cpu_we && !reset;
    assign ram_wdata = cpu_wdata;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            C_IDLE: begin
                if (grant)
                    state_d = C_CAPT;
                else if (block)
                    state_d = C_WAIT;
            end
            C_WAIT: begin
                if (grant)
                    state_d = C_CAPT;
            end
            C_CAPT:  state_d = C_ACK;
            C_ACK:   state_d = C_IDLE;
            default: state_d = C_IDLE;
        endcase
    end

    always_comb begin
        wait_inc  = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
        wait_d    = 8'd0;
        timeout_d = timeout_q;
        if (state_q == C_WAIT) begin
            if (state_d == C_WAIT)
                wait_d = wait_inc;
            if (wait_inc >= MAX_WAIT_C)
                timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q     <= C_IDLE;
            wait_q      <= 8'd0;
            timeout_q   <= 1'b0;
            ack_q       <= 1'b0;
            we_q        <= 1'b0;
            disp_pend_q <= 1'b0;
            disp_data_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            timeout_q   <= timeout_d;
            ack_q       <= (state_q == C_CAPT);
            disp_pend_q <= disp_req;
            if (grant)
                we_q <= cpu_we;
            if (disp_pend_q)
                disp_data_q <= ram_rdata;
            // RAM data for the granted CPU read is valid in the capture cycle.
            if (state_q == C_CAPT && !we_q)
                cpu_rdata_q <= ram_rdata;
        end
    end

    assign disp_data   = disp_data_q;
    assign cpu_ack     = ack_q;
    assign cpu_rdata   = cpu_rdata_q;
    assign cpu_timeout = timeout_q;

`ifdef VGAHDMI_ARB_STATS_EN
    logic [15:0] conflict_q;

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset)
            conflict_q <= 16'd0;
        else if (block && conflict_q != 16'hFFFF)
            conflict_q <= conflict_q + 16'd1;
    end

    assign conflict_cnt = conflict_q;
`endif

endmodule
